// File: rtl/rr_requester_if.sv
// Job-queue and arbiter-handshake bundle for rr_requester.
// The slave modport is the requester; the master modport is the local
// job source plus the arbiter side.
interface rr_requester_if #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 16
);
    logic             job_valid;
    logic [LEN_W-1:0] job_len;
    logic             job_ready;
    logic             req;
    logic             ack;
    logic             beat;
    logic             beat_last;
    logic             busy;
    logic             starve;
    logic [CNT_W-1:0] beat_cnt;

    modport slave (
        input  job_valid, job_len, ack,
        output job_ready, req, beat, beat_last, busy, starve, beat_cnt
    );

    modport master (
        output job_valid, job_len, ack,
        input  job_ready, req, beat, beat_last, busy, starve, beat_cnt
    );
endinterface

// File: rtl/rr_requester.sv
// Client agent for a two-way round-robin arbiter: queues burst jobs,
// holds req while a job is in flight, issues one beat per granted cycle,
// then drops req for a guard gap so the arbiter rotates to the other client.
module rr_requester #(
    parameter int LEN_W    = 4,
    parameter int DEPTH    = 4,
    parameter int GAP_CYC  = 2,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input logic           clock,
    input logic           reset,
    rr_requester_if.slave bus
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W + 1)'(DEPTH);
    localparam logic [WAIT_W-1:0] MAXW_C   = WAIT_W'(MAX_WAIT);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [LEN_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic [LEN_W-1:0]  r_remaining;
    logic [GAP_W-1:0]  r_gap;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_req;
    logic              r_starve;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic              w_job_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_beat;
    logic              w_beat_last;

    assign w_job_ready = (r_count < DEPTH_C);
    // Zero-length jobs complete the handshake but are dropped here.
    assign w_push      = bus.job_valid & w_job_ready & (bus.job_len != '0);
    assign w_beat      = r_req & bus.ack & (r_state == S_XFER);
    assign w_beat_last = w_beat & (r_remaining == LEN_W'(1));

    assign bus.job_ready = w_job_ready;
    assign bus.req       = r_req;
    assign bus.beat      = w_beat;
    assign bus.beat_last = w_beat_last;
    assign bus.busy      = (r_state != S_IDLE) | (r_count != '0);
    assign bus.starve    = r_starve;
    assign bus.beat_cnt  = r_beat_cnt;

    // Next-state decode; the pop only happens from IDLE with a non-empty queue.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (w_beat_last) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Ungranted-cycle counter: counts only while staying in XFER without ack.
    always_comb begin
        w_wait_nxt = '0;
        if (r_state == S_XFER && w_state_nxt == S_XFER && !bus.ack) begin
            w_wait_nxt = (r_wait == MAXW_C) ? r_wait : r_wait + WAIT_W'(1);
        end
    end

    // Job FIFO storage; contents need no reset since count gates reads.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.job_len;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // State register plus burst, gap, starvation and statistics registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_gap       <= '0;
            r_wait      <= '0;
            r_req       <= 1'b0;
            r_starve    <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == S_XFER);
            r_wait  <= w_wait_nxt;

            if (w_pop) begin
                r_remaining <= r_mem[r_rd_ptr];
            end else if (w_beat) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end

            if (w_beat_last) begin
                r_gap <= GAP_LOAD;
            end else if (r_state == S_GAP && r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end

            if (w_wait_nxt == MAXW_C) begin
                r_starve <= 1'b1;
            end

            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rr_requester.sv
// Directed bench for rr_requester with hand-computed expectations.
module tb_rr_requester;
    localparam int LEN_W = 4;
    localparam int CNT_W = 16;

    logic clock;
    logic reset;

    int n_checks;
    int n_errors;

    rr_requester_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    rr_requester #(
        .LEN_W   (LEN_W),
        .DEPTH   (4),
        .GAP_CYC (2),
        .MAX_WAIT(8),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [LEN_W-1:0] len);
        bus.job_valid = 1'b1;
        bus.job_len   = len;
        step();
        bus.job_valid = 1'b0;
        bus.job_len   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int beats;
        int rises;
        int req_hi;
        logic prev_req;

        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.job_valid = 1'b0;
        bus.job_len   = '0;
        bus.ack       = 1'b0;
        step();
        step();
        reset = 1'b0;
        settle();

        check("rst_req",   32'(bus.req), 0);
        check("rst_ready", 32'(bus.job_ready), 1);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_starve", 32'(bus.starve), 0);
        check("rst_cnt",   32'(bus.beat_cnt), 0);

        // Single job, ack held high.
        bus.ack = 1'b1;
        push(4'd3);                       // edge 0
        settle();
        check("t1_req_e0", 32'(bus.req), 0);
        check("t1_busy_e0", 32'(bus.busy), 1);
        step();                           // edge 1: pop
        check("t1_req_e1", 32'(bus.req), 1);
        check("t1_beat_a", 32'({bus.beat, bus.beat_last}), 32'b10);
        step();                           // edge 2
        check("t1_beat_b", 32'({bus.beat, bus.beat_last}), 32'b10);
        step();                           // edge 3
        check("t1_beat_c", 32'({bus.beat, bus.beat_last}), 32'b11);
        step();                           // edge 4
        check("t1_req_e4", 32'({bus.req, bus.beat}), 0);
        check("t1_cnt", 32'(bus.beat_cnt), 3);
        bus.ack = 1'b0;
        step();
        check("t1_req_e5", 32'(bus.req), 0);
        step();
        check("t1_req_e6", 32'(bus.req), 0);
        step();
        check("t1_idle", 32'({bus.req, bus.busy}), 0);

        // Interleaved grant: 4 beats over 7 cycles.
        push(4'd4);
        step();
        beats = 0;
        for (int i = 0; i < 7; i++) begin
            bus.ack = (i % 2 == 0);
            settle();
            beats += int'(bus.beat);
            if (i == 6) check("t2_last", 32'(bus.beat_last), 1);
            if (i == 4) check("t2_notlast", 32'(bus.beat_last), 0);
            step();
        end
        bus.ack = 1'b0;
        check("t2_beats", 32'(beats), 4);
        check("t2_cnt", 32'(bus.beat_cnt), 7);
        check("t2_starve", 32'(bus.starve), 0);
        check("t2_req_gap", 32'(bus.req), 0);
        step();
        step();
        step();

        // Stale ack during GAP.
        push(4'd1);
        step();
        bus.ack = 1'b1;
        settle();
        check("t3_beat", 32'({bus.beat, bus.beat_last}), 32'b11);
        step();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_stale", 32'({bus.req, bus.beat}), 0);
            step();
        end
        bus.ack = 1'b0;
        check("t3_cnt", 32'(bus.beat_cnt), 8);

        // Queue full: one job in flight, then five more offered back-to-back.
        bus.job_valid = 1'b1;
        bus.job_len   = 4'd7;
        step();
        for (int i = 1; i <= 5; i++) begin
            bus.job_len = LEN_W'(i);
            step();
            if (i == 4) check("t4_full", 32'(bus.job_ready), 0);
        end
        bus.job_valid = 1'b0;
        bus.job_len   = '0;
        check("t4_full2", 32'(bus.job_ready), 0);
        bus.ack  = 1'b1;
        beats    = 0;
        rises    = 0;
        prev_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            settle();
            beats += int'(bus.beat);
            if (bus.req && !prev_req) rises++;
            prev_req = bus.req;
            step();
        end
        check("t4_beats", 32'(beats), 17);
        check("t4_jobs", 32'(rises), 4);
        check("t4_cnt", 32'(bus.beat_cnt), 25);
        check("t4_drained", 32'({bus.busy, bus.starve}), 0);

        // Zero-length job: accepted, never requested.
        bus.ack       = 1'b0;
        bus.job_valid = 1'b1;
        bus.job_len   = '0;
        settle();
        check("t5_ready", 32'(bus.job_ready), 1);
        step();
        bus.job_valid = 1'b0;
        req_hi = 0;
        for (int i = 0; i < 6; i++) begin
            req_hi += int'(bus.req) + int'(bus.busy);
            step();
        end
        check("t5_noreq", 32'(req_hi), 0);

        // Starvation: 8 ungranted edges in XFER.
        push(4'd2);
        step();
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 7) check("t6_starve7", 32'(bus.starve), 0);
            if (i == 8) check("t6_starve8", 32'(bus.starve), 1);
        end
        bus.ack = 1'b1;
        step();
        step();
        bus.ack = 1'b0;
        check("t6_done", 32'({bus.req, bus.starve}), 32'b01);
        check("t6_cnt", 32'(bus.beat_cnt), 27);
        step();
        step();
        step();
        check("t6_sticky", 32'(bus.starve), 1);

        // Reset mid-burst: remaining=5 with two jobs queued.
        push(4'd5);
        bus.job_valid = 1'b1;
        bus.job_len   = 4'd3;
        step();
        bus.job_len   = 4'd4;
        step();
        bus.job_valid = 1'b0;
        bus.job_len   = '0;
        check("t7_pre", 32'({bus.req, bus.busy}), 32'b11);
        bus.ack = 1'b1;
        reset   = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check("t7_outs", 32'({bus.req, bus.beat, bus.busy, bus.starve, bus.job_ready}), 32'b00001);
        check("t7_cnt", 32'(bus.beat_cnt), 0);
        req_hi = 0;
        for (int i = 0; i < 6; i++) begin
            req_hi += int'(bus.req) + int'(bus.beat);
            step();
        end
        check("t7_noreq", 32'(req_hi), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
